// File: rtl/sbox_share_sched.sv
// sbox_share_sched
// Shares a narrow bank of LANES combinational AES S-boxes between the cipher
// state path (16-byte SubBytes) and the key expansion path (4-byte SubWord).
// Requests are arbitrated round-robin. The captured operand is streamed
// through the bank LANES bytes per beat. The assembled result is then held
// on a valid/ready response channel until the consumer takes it.
module sbox_share_sched #(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               st_req_valid,
   output logic               st_req_ready,
   input  logic [127:0]       st_req_data,
   input  logic               kx_req_valid,
   output logic               kx_req_ready,
   input  logic [31:0]        kx_req_word,
   output logic               st_rsp_valid,
   input  logic               st_rsp_ready,
   output logic [127:0]       st_rsp_data,
   output logic               kx_rsp_valid,
   input  logic               kx_rsp_ready,
   output logic [31:0]        kx_rsp_word,
   output logic [8*LANES-1:0] sbox_in,
   input  logic [8*LANES-1:0] sbox_out,
   output logic               busy
);

   localparam int W     = 8 * LANES;
   localparam int NB_ST = 16 / LANES;
   localparam int NB_KX = 4 / LANES;
   localparam int CW    = (NB_ST > 1) ? $clog2(NB_ST) : 1;

   localparam logic [CW-1:0] LAST_ST = CW'(NB_ST - 1);
   localparam logic [CW-1:0] LAST_KX = CW'(NB_KX - 1);

   localparam logic GRANT_ST = 1'b0;
   localparam logic GRANT_KX = 1'b1;

   // Only bank widths that divide a 32-bit word evenly are supported.
   if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
      $error("sbox_share_sched: LANES must be 1, 2 or 4");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ST_RUN  = 3'd1,
      KX_RUN  = 3'd2,
      ST_HOLD = 3'd3,
      KX_HOLD = 3'd4
   } state_t;

   state_t                     state_r;
   state_t                     state_s;
   logic                       last_grant_r;
   logic [CW-1:0]              beat_r;
   logic [NB_ST-1:0][W-1:0]    cap_r;
   logic [NB_ST-1:0][W-1:0]    st_res_r;
   logic [31:0]                kx_res_r;

   assign st_rsp_data = st_res_r;
   assign kx_rsp_word = kx_res_r;

   // State register; reset mid-job simply abandons the job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: accept in IDLE, stream beats, hold until the response is taken.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (st_req_ready) begin
               state_s = ST_RUN;
            end else if (kx_req_ready) begin
               state_s = KX_RUN;
            end else begin
               state_s = IDLE;
            end
         end
         ST_RUN: begin
            if (beat_r == LAST_ST) begin
               state_s = ST_HOLD;
            end else begin
               state_s = ST_RUN;
            end
         end
         KX_RUN: begin
            if (beat_r == LAST_KX) begin
               state_s = KX_HOLD;
            end else begin
               state_s = KX_RUN;
            end
         end
         ST_HOLD: begin
            if (st_rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         KX_HOLD: begin
            if (kx_rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = KX_HOLD;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Output decode. In IDLE, ready goes to the single valid requester; on a tie it goes to the requester not granted last.
   always_comb begin
      st_req_ready = 1'b0;
      kx_req_ready = 1'b0;
      st_rsp_valid = 1'b0;
      kx_rsp_valid = 1'b0;
      sbox_in      = '0;
      busy         = 1'b1;
      case (state_r)
         IDLE: begin
            busy = 1'b0;
            if (rst_n && st_req_valid && (!kx_req_valid || (last_grant_r == GRANT_KX))) begin
               st_req_ready = 1'b1;
            end else begin
               st_req_ready = 1'b0;
            end
            if (rst_n && kx_req_valid && (!st_req_valid || (last_grant_r == GRANT_ST))) begin
               kx_req_ready = 1'b1;
            end else begin
               kx_req_ready = 1'b0;
            end
         end
         ST_RUN:  sbox_in = cap_r[beat_r];
         KX_RUN:  sbox_in = cap_r[beat_r];
         ST_HOLD: st_rsp_valid = 1'b1;
         KX_HOLD: kx_rsp_valid = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Datapath: capture the operand on acceptance, then register one slice of bank output per beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= GRANT_ST;
         beat_r       <= '0;
         cap_r        <= '0;
         st_res_r     <= '0;
         kx_res_r     <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (st_req_ready) begin
                  cap_r        <= st_req_data;
                  last_grant_r <= GRANT_ST;
                  beat_r       <= '0;
               end else if (kx_req_ready) begin
                  cap_r        <= {96'd0, kx_req_word};
                  last_grant_r <= GRANT_KX;
                  beat_r       <= '0;
               end
            end
            ST_RUN: begin
               st_res_r[beat_r] <= sbox_out;
               beat_r <= (beat_r == LAST_ST) ? '0 : beat_r + CW'(1);
            end
            KX_RUN: begin
               for (int b = 0; b < NB_KX; b++) begin
                  if (beat_r == CW'(b)) begin
                     kx_res_r[W*b +: W] <= sbox_out;
                  end
               end
               beat_r <= (beat_r == LAST_KX) ? '0 : beat_r + CW'(1);
            end
            default: beat_r <= beat_r;
         endcase
      end
   end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Testbench for sbox_share_sched. It uses a computed AES S-box as the bank,
// a scoreboard fed at acceptance and drained at response handshakes, a
// vector table, and hand sequences for arbitration, hold and reset.
module tb_sbox_share_sched;

   parameter int LANES = 4;
   localparam int W     = 8 * LANES;
   localparam int NB_ST = 16 / LANES;
   localparam int NB_KX = 4 / LANES;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           st_req_valid = 1'b0;
   logic           st_req_ready;
   logic [127:0]   st_req_data = 128'd0;
   logic           kx_req_valid = 1'b0;
   logic           kx_req_ready;
   logic [31:0]    kx_req_word = 32'd0;
   logic           st_rsp_valid;
   logic           st_rsp_ready = 1'b1;
   logic [127:0]   st_rsp_data;
   logic           kx_rsp_valid;
   logic           kx_rsp_ready = 1'b1;
   logic [31:0]    kx_rsp_word;
   logic [W-1:0]   sbox_in;
   logic [W-1:0]   sbox_out;
   logic           busy;

   int checks = 0;
   int failures = 0;

   logic [7:0]   sbox_tbl [256];
   logic [127:0] st_q [$];
   logic [31:0]  kx_q [$];
   int           grant_q [$];

   always #5 clk = ~clk;

   sbox_share_sched #(.LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_data(st_req_data),
      .kx_req_valid(kx_req_valid), .kx_req_ready(kx_req_ready), .kx_req_word(kx_req_word),
      .st_rsp_valid(st_rsp_valid), .st_rsp_ready(st_rsp_ready), .st_rsp_data(st_rsp_data),
      .kx_rsp_valid(kx_rsp_valid), .kx_rsp_ready(kx_rsp_ready), .kx_rsp_word(kx_rsp_word),
      .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
   );

   for (genvar j = 0; j < LANES; j++) begin : g_bank
      assign sbox_out[8*j +: 8] = sbox_tbl[sbox_in[8*j +: 8]];
   end

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [7:0] r;
      r = (x << n) | (x >> (8 - n));
      return r;
   endfunction

   function automatic void build_sbox();
      logic [7:0] inv, xb, yb;
      for (int x = 0; x < 256; x++) begin
         inv = 8'd0;
         xb = 8'(x);
         for (int y = 1; y < 256; y++) begin
            yb = 8'(y);
            if (gmul(xb, yb) == 8'd1) inv = yb;
         end
         sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tbl[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tbl[d[8*i +: 8]];
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard: push at acceptance, pop and compare at response handshake.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         check("ready_exclusive", 128'(st_req_ready & kx_req_ready), 128'd0);
         check("rsp_valid_exclusive", 128'(st_rsp_valid & kx_rsp_valid), 128'd0);
         if (st_req_valid && st_req_ready) begin
            st_q.push_back(sub_bytes(st_req_data));
            grant_q.push_back(0);
         end
         if (kx_req_valid && kx_req_ready) begin
            kx_q.push_back(sub_word(kx_req_word));
            grant_q.push_back(1);
         end
         if (st_rsp_valid && st_rsp_ready) begin
            if (st_q.size() == 0) check("st_unexpected_rsp", 128'd1, 128'd0);
            else check("sb_st_rsp_data", st_rsp_data, st_q.pop_front());
         end
         if (kx_rsp_valid && kx_rsp_ready) begin
            if (kx_q.size() == 0) check("kx_unexpected_rsp", 128'd1, 128'd0);
            else check("sb_kx_rsp_word", 128'(kx_rsp_word), 128'(kx_q.pop_front()));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic accept(input bit is_kx, input logic [127:0] d);
      int n;
      n = 0;
      @(negedge clk);
      if (is_kx) begin kx_req_valid = 1'b1; kx_req_word = d[31:0]; end
      else begin st_req_valid = 1'b1; st_req_data = d; end
      #1;
      while (!(is_kx ? kx_req_ready : st_req_ready) && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check("req_accept", 128'(n < 100), 128'd1);
      @(posedge clk);
   endtask

   task automatic run_job(input bit is_kx, input logic [127:0] d, input logic [127:0] exp, input int lat);
      int seen;
      seen = 0;
      accept(is_kx, d);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 1) begin st_req_valid = 1'b0; kx_req_valid = 1'b0; end
         #1;
         if (k == 1) check("sbox_in_first_beat", 128'(sbox_in), 128'(d[W-1:0]));
         check("busy_during_job", 128'(busy), 128'd1);
         if (is_kx ? kx_rsp_valid : st_rsp_valid) begin seen = k; break; end
      end
      check(is_kx ? "kx_latency" : "st_latency", 128'(seen), 128'(lat));
      if (is_kx) check("kx_rsp_word", 128'(kx_rsp_word), exp);
      else check("st_rsp_data", st_rsp_data, exp);
      @(negedge clk); #1;
      check("rsp_valid_dropped", 128'({st_rsp_valid, kx_rsp_valid}), 128'd0);
      check("idle_after_rsp", 128'(busy), 128'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk); #1;
      while ((busy || st_rsp_valid || kx_rsp_valid) && n < 200) begin
         @(negedge clk); #1; n++;
      end
      check("idle_timeout", 128'(n < 200), 128'd1);
   endtask

   typedef struct {
      bit           is_kx;
      logic [127:0] data;
      logic [127:0] exp;
      int           lat;
   } vec_t;

   vec_t vec [6];

   initial begin
      int ngrant;
      int seen_valid;
      logic [3:0]   gord;
      logic [127:0] held;
      logic [127:0] d;

      build_sbox();
      vec[0] = '{1'b0, 128'h00112233445566778899aabbccddeeff,
                 128'h638293c31bfc33f5c4eeacea4bc12816, NB_ST + 1};
      vec[1] = '{1'b1, 128'h01020304, 128'h7c777bf2, NB_KX + 1};
      for (int i = 2; i < 6; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         vec[i].is_kx = (i % 2) == 1;
         vec[i].data  = vec[i].is_kx ? {96'd0, d[31:0]} : d;
         vec[i].exp   = vec[i].is_kx ? {96'd0, sub_word(d[31:0])} : sub_bytes(d);
         vec[i].lat   = vec[i].is_kx ? NB_KX + 1 : NB_ST + 1;
      end

      // Reset state
      #12;
      check("reset_outputs", {st_req_ready, kx_req_ready, st_rsp_valid, kx_rsp_valid, busy, 123'd0}, 128'd0);
      check("reset_st_data", st_rsp_data, 128'd0);
      check("reset_kx_sbox", {64'd0, kx_rsp_word, 32'(sbox_in)}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Arbitration: both requesters valid every cycle straight after reset
      grant_q.delete();
      ngrant = 0;
      for (int i = 0; i < 300 && ngrant < 4; i++) begin
         @(negedge clk);
         st_req_valid = 1'b1; kx_req_valid = 1'b1;
         st_req_data = {$urandom, $urandom, $urandom, $urandom};
         kx_req_word = $urandom;
         #1;
         if (st_req_ready || kx_req_ready) ngrant++;
      end
      @(negedge clk);
      st_req_valid = 1'b0; kx_req_valid = 1'b0;
      wait_idle();
      check("grant_count", 128'(grant_q.size()), 128'd4);
      gord = 4'd0;
      for (int i = 0; i < grant_q.size() && i < 4; i++) gord = {gord[2:0], grant_q[i][0]};
      check("grant_order", 128'(gord), 128'(4'b1010));

      // Vector table
      for (int i = 0; i < 6; i++) run_job(vec[i].is_kx, vec[i].data, vec[i].exp, vec[i].lat);

      // Back-pressure: response held, kx request pending meanwhile
      st_rsp_ready = 1'b0;
      accept(1'b0, vec[0].data);
      @(negedge clk);
      st_req_valid = 1'b0;
      kx_req_valid = 1'b1; kx_req_word = 32'h01020304;
      #1;
      seen_valid = 0;
      for (int k = 0; k < 40; k++) begin
         if (st_rsp_valid) begin seen_valid = 1; break; end
         @(negedge clk); #1;
      end
      check("hold_valid_seen", 128'(seen_valid), 128'd1);
      held = st_rsp_data;
      check("hold_data", held, vec[0].exp);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         check("hold_valid", 128'(st_rsp_valid), 128'd1);
         check("hold_data_stable", st_rsp_data, held);
         check("hold_kx_ready", 128'(kx_req_ready), 128'd0);
      end
      @(negedge clk);
      st_rsp_ready = 1'b1;
      @(negedge clk); #1;
      check("release_st_valid", 128'(st_rsp_valid), 128'd0);
      check("release_kx_ready", 128'(kx_req_ready), 128'd1);
      @(negedge clk);
      kx_req_valid = 1'b0;
      wait_idle();

      // Reset during beat 2 of a state job
      accept(1'b0, vec[2].is_kx ? vec[0].data : vec[2].data);
      @(negedge clk); st_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", {st_req_ready, kx_req_ready, st_rsp_valid, kx_rsp_valid, busy, 123'd0}, 128'd0);
      check("midreset_st_data", st_rsp_data, 128'd0);
      check("midreset_sbox_in", 128'(sbox_in), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      st_q.delete();
      seen_valid = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk); #1;
         if (st_rsp_valid || busy) seen_valid = 1;
      end
      check("no_rsp_after_reset", 128'(seen_valid), 128'd0);
      run_job(1'b0, vec[0].data, vec[0].exp, NB_ST + 1);
      run_job(1'b1, vec[1].data, vec[1].exp, NB_KX + 1);

      wait_idle();
      check("st_queue_drained", 128'(st_q.size()), 128'd0);
      check("kx_queue_drained", 128'(kx_q.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
Time-multiplexes a narrow bank of LANES combinational AES S-boxes between two requesters. The cipher datapath requests a full 128-bit SubBytes and the key-expansion unit requests a 32-bit SubWord. The block arbitrates between them, feeds the shared bank LANES bytes per cycle, assembles the result, and returns it over a valid/ready response channel. It sits between the round datapath, the key schedule and the external S-box bank, replacing one full-width substitution array per consumer.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2 or 4; the external bank holds LANES S-boxes.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
st_req_valid  in  1  state request valid
st_req_ready  out  1  state request accepted this cycle when valid&&ready
st_req_data  in  128  state bytes; byte i = [8*i +: 8]
kx_req_valid  in  1  key-word request valid
kx_req_ready  out  1  key-word request accepted when valid&&ready
kx_req_word  in  32  key word; byte i = [8*i +: 8]
st_rsp_valid  out  1  substituted state available
st_rsp_ready  in  1  consumer takes state result
st_rsp_data  out  128  SubBytes(st_req_data), same byte order
kx_rsp_valid  out  1  substituted word available
kx_rsp_ready  in  1  consumer takes word result
kx_rsp_word  out  32  SubWord(kx_req_word)
sbox_in  out  8*LANES  bytes to the S-box bank; lane j = [8*j +: 8]
sbox_out  in  8*LANES  bank outputs, combinational from sbox_in, lane-aligned
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; the result registers and beat counter clear.
  - last_grant=ST, so the first conflict after reset goes to KX.
  - Reset mid-job drops the job silently; no response is produced.
- FSM states: IDLE, ST_RUN, KX_RUN, ST_HOLD, KX_HOLD.
- IDLE:
  - Ready outputs are combinational; at most one is high per cycle.
  - Only st valid: st_req_ready=1. Only kx valid: kx_req_ready=1.
  - Both valid: grant the requester not equal to last_grant (round-robin).
  - On acceptance, capture the request data, set last_grant, clear the beat counter, and go to ST_RUN or KX_RUN.
  - Ready is 0 in every non-IDLE state.
- ST_RUN runs NB_ST = 16/LANES beats; KX_RUN runs NB_KX = 4/LANES beats.
  - Beat k drives sbox_in = captured[8*LANES*k +: 8*LANES].
  - The result register slot at the same offset registers sbox_out at the end of the cycle.
  - After the last beat, go to the matching HOLD state.
- sbox_in = 0 in IDLE and HOLD states.
- Latency (LANES=4, acceptance at edge T):
  - State job: beats in cycles T+1..T+4, st_rsp_valid high from T+5.
  - Key job: single beat at T+1, kx_rsp_valid high from T+2.
  - General case: valid appears NB+1 cycles after acceptance.
- HOLD states:
  - rsp_valid=1 and rsp data held stable until rsp_ready=1 is sampled.
  - On that edge rsp_valid drops and the FSM returns to IDLE.
  - The next request can be accepted one cycle after the response handshake.
  - The other channel's rsp_valid stays 0.
- Responses are only visible while valid; the data bus keeps its last value otherwise. Benches must not check data when valid=0.
- rsp_ready held high before valid has no effect.
- Request signals that change while not accepted are ignored; only the data sampled on the acceptance edge is used.
- Beat counter width is $clog2(16/LANES), minimum 1; it wraps to 0 on job completion.
- An illegal LANES value is a static error; elaboration must fail via a generate-time check.

Test Plan:
- LANES=4, S-box bank modelled with the standard AES table: st_req_data=128'h00112233445566778899aabbccddeeff accepted at T -> st_rsp_data=128'h638293c31bfc33f5c4eeacea4bc12816 with st_rsp_valid rising at T+5; sbox_in=32'hccddeeff at T+1.
- kx_req_word=32'h01020304 accepted at T -> kx_rsp_word=32'h7c777bf2 with valid at T+2; busy=1 for cycles T+1..T+2.
- Both valid every cycle right after reset -> grants alternate KX, ST, KX, ST.
  - Ready is never high on both channels together.
  - Each response matches its own request.
- st_rsp_ready held 0 for 10 cycles -> st_rsp_valid and st_rsp_data stay constant, kx_req_ready stays 0; releasing ready gives IDLE next cycle and accepts a pending kx request.
- rst_n pulsed low during ST_RUN beat 2 -> all outputs 0 immediately, no response afterwards; a fresh request afterwards completes correctly.
- LANES=1 and LANES=2 with the same vectors -> identical results; state latency 17 and 9 cycles, key latency 5 and 3 cycles.
